// File: rtl/axis_video_timing_out.sv
// Raster timing generator that pulls one AXI-stream beat per active pixel and
// drives registered hsync/vsync/de/pixel, resynchronising to tuser after errors.
module axis_video_timing_out #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_axis_tvalid,
    output logic             in_axis_tready,
    input  logic             in_axis_tuser,
    input  logic             in_axis_tlast,
    input  logic [WIDTH-1:0] in_axis_tdata,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic [WIDTH-1:0] pixel_o,
    output logic             underflow_o,
    output logic             sync_err_o,
    output logic [1:0]       status_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 12-bit limits so a region end equal to 2048 still compares correctly
    localparam logic [11:0] HA_L   = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VA_L   = 12'(V_ACTIVE);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_EOL  = 11'(H_ACTIVE - 1);

    typedef enum logic [1:0] {
        RESYNC = 2'b00,
        ARMED  = 2'b01,
        RUN    = 2'b10
    } state_t;

    state_t      r_state;
    logic [10:0] r_h;
    logic [10:0] r_v;

    logic [11:0] w_h12;
    logic [11:0] w_v12;
    logic        w_active;
    logic        w_hs;
    logic        w_vs;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_beat_ok;

    assign w_h12     = {1'b0, r_h};
    assign w_v12     = {1'b0, r_v};
    assign w_active  = (w_h12 < HA_L) && (w_v12 < VA_L);
    assign w_hs      = (w_h12 >= HS_BEG) && (w_h12 < HS_END);
    assign w_vs      = (w_v12 >= VS_BEG) && (w_v12 < VS_END);
    assign w_h_last  = (r_h == H_LAST);
    assign w_v_last  = (r_v == V_LAST);
    assign w_beat_ok = (in_axis_tuser == ((r_h == '0) && (r_v == '0))) &&
                       (in_axis_tlast == (r_h == H_EOL));
    assign status_o  = r_state;

    // In RESYNC everything except a frame-start beat is drained so the
    // upstream reaches its next tuser as quickly as possible.
    always_comb begin
        in_axis_tready = 1'b0;
        case (r_state)
            RESYNC:  in_axis_tready = !(in_axis_tvalid && in_axis_tuser);
            RUN:     in_axis_tready = w_active;
            default: in_axis_tready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h         <= '0;
            r_v         <= '0;
            r_state     <= RESYNC;
            de_o        <= 1'b0;
            pixel_o     <= '0;
            hsync_o     <= ~HS_POL;
            vsync_o     <= ~VS_POL;
            underflow_o <= 1'b0;
            sync_err_o  <= 1'b0;
        end else begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + 11'd1;
            end else begin
                r_h <= r_h + 11'd1;
            end

            de_o    <= w_active;
            hsync_o <= w_hs ? HS_POL : ~HS_POL;
            vsync_o <= w_vs ? VS_POL : ~VS_POL;
            pixel_o <= '0;

            case (r_state)
                RESYNC: begin
                    if (in_axis_tvalid && in_axis_tuser)
                        r_state <= ARMED;
                end
                ARMED: begin
                    if (w_h_last && w_v_last)
                        r_state <= RUN;
                end
                RUN: begin
                    if (w_active) begin
                        if (in_axis_tvalid) begin
                            pixel_o <= in_axis_tdata;
                            if (!w_beat_ok) begin
                                sync_err_o <= 1'b1;
                                r_state    <= RESYNC;
                            end
                        end else begin
                            underflow_o <= 1'b1;
                            r_state     <= RESYNC;
                        end
                    end
                end
                default: r_state <= RESYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_video_timing_out.sv
// Bench for axis_video_timing_out on a small 8x4 raster: a frame-level model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_axis_video_timing_out;

    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HSY = 3;
    localparam int HBP = 3;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VSY = 2;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int FR  = HT * VT;
    localparam int NPIX = HA * VA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_axis_tvalid = 1'b0;
    logic        in_axis_tready;
    logic        in_axis_tuser = 1'b0;
    logic        in_axis_tlast = 1'b0;
    logic [31:0] in_axis_tdata = '0;
    logic        hsync_o;
    logic        vsync_o;
    logic        de_o;
    logic [31:0] pixel_o;
    logic        underflow_o;
    logic        sync_err_o;
    logic [1:0]  status_o;

    axis_video_timing_out #(
        .WIDTH(32), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .in_axis_tvalid(in_axis_tvalid), .in_axis_tready(in_axis_tready),
        .in_axis_tuser(in_axis_tuser), .in_axis_tlast(in_axis_tlast),
        .in_axis_tdata(in_axis_tdata),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .pixel_o(pixel_o),
        .underflow_o(underflow_o), .sync_err_o(sync_err_o), .status_o(status_o)
    );

    initial forever #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Frame-level model: position is derived from cycles since reset; lock is
    // the absolute frame index from which the stream is displayed (-1 = none).
    bit          m_ok = 1'b0;
    int          m_t = 0;
    int          m_arm = -1;
    logic        e_de, e_hs, e_vs, e_uf, e_se;
    logic [31:0] e_pix;
    int          mh, mv;
    bit          mact, mrun, mrdy;
    logic [1:0]  mst;

    always @(negedge clk) begin
        if (m_ok) begin
            mh   = m_t % HT;
            mv   = (m_t / HT) % VT;
            mact = (mh < HA) && (mv < VA);
            mrun = (m_arm >= 0) && ((m_t / FR) >= m_arm);
            if (mrun) begin
                mst = 2'b10; mrdy = mact;
            end else if (m_arm >= 0) begin
                mst = 2'b01; mrdy = 1'b0;
            end else begin
                mst = 2'b00; mrdy = !(in_axis_tvalid && in_axis_tuser);
            end
            chk("de", 32'(de_o), 32'(e_de));
            chk("hsync", 32'(hsync_o), 32'(e_hs));
            chk("vsync", 32'(vsync_o), 32'(e_vs));
            chk("pixel", pixel_o, e_pix);
            chk("underflow", 32'(underflow_o), 32'(e_uf));
            chk("sync_err", 32'(sync_err_o), 32'(e_se));
            chk("tready", 32'(in_axis_tready), 32'(mrdy));
            chk("status", 32'(status_o), 32'(mst));
        end
        if (rst) begin
            m_ok = 1'b1; m_t = 0; m_arm = -1;
            e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_pix = '0; e_uf = 1'b0; e_se = 1'b0;
        end else if (m_ok) begin
            e_de  = mact;
            e_hs  = !((mh >= HA + HFP) && (mh < HA + HFP + HSY));
            e_vs  = !((mv >= VA + VFP) && (mv < VA + VFP + VSY));
            e_pix = '0;
            if (mrun && mact) begin
                if (in_axis_tvalid) begin
                    e_pix = in_axis_tdata;
                    if ((in_axis_tuser != (mh == 0 && mv == 0)) || (in_axis_tlast != (mh == HA - 1))) begin
                        e_se = 1'b1; m_arm = -1;
                    end
                end else begin
                    e_uf = 1'b1; m_arm = -1;
                end
            end else if (m_arm < 0 && in_axis_tvalid && in_axis_tuser) begin
                m_arm = (m_t + 1) / FR + 1;
            end
            m_t++;
        end
    end

    // Upstream source: optional junk beats, then endless frames of {v,h}.
    bit src_en = 1'b0;
    int junk = 0;
    int junk_acc = 0;
    bit drop_arm = 1'b0;
    bit lerr = 1'b0;
    int p = 0;
    bit fire, drop_now;

    initial begin
        forever begin
            @(negedge clk);
            fire = in_axis_tvalid && in_axis_tready;
            @(posedge clk);
            #1;
            if (fire) begin
                if (junk > 0) begin
                    junk--; junk_acc++;
                end else begin
                    if (lerr && p == 6) lerr = 1'b0;
                    p = (p + 1) % NPIX;
                end
            end
            drop_now = drop_arm && junk == 0 && p == 11;
            if (drop_now) drop_arm = 1'b0;
            in_axis_tvalid = src_en && !drop_now;
            if (junk > 0) begin
                in_axis_tuser = 1'b0;
                in_axis_tlast = 1'b0;
                in_axis_tdata = 32'hBAD0_0000 | 32'(junk);
            end else begin
                in_axis_tuser = (p == 0);
                in_axis_tlast = (p % HA == HA - 1) || (lerr && p == 6);
                in_axis_tdata = 32'(((p / HA) << 11) | (p % HA));
            end
        end
    end

    // Waits (bounded) until the DUT counters sit at (h,v), optionally in RUN.
    task automatic wait_at(input string nm, input int h, input int v, input bit need_run);
        bit hit = 1'b0;
        for (int i = 0; i < 4 * FR && !hit; i++) begin
            @(posedge clk); #1;
            if ((m_t % HT) == h && ((m_t / HT) % VT) == v &&
                (!need_run || (m_arm >= 0 && (m_t / FR) >= m_arm)))
                hit = 1'b1;
        end
        if (!hit) begin
            n_vec++; n_mis++;
            $display("FAIL wait_%s: position h=%0d v=%0d not reached", nm, h, v);
        end
    endtask

    initial begin : main
        int cnt_de, cnt_hs, cnt_vs, h, v;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle raster, no upstream data
        cnt_de = 0; cnt_hs = 0; cnt_vs = 0;
        for (int i = 0; i < FR; i++) begin
            @(posedge clk); #1;
            h = m_t % HT; v = (m_t / HT) % VT;
            if (v == 0 && h == 10) chk("hs_before_pulse", 32'(hsync_o), 32'd1);
            if (v == 0 && h == 11) chk("hs_first_low", 32'(hsync_o), 32'd0);
            if (v == 0 && h == 13) chk("hs_last_low", 32'(hsync_o), 32'd0);
            if (v == 0 && h == 14) chk("hs_after_pulse", 32'(hsync_o), 32'd1);
            if (de_o) cnt_de++;
            if (!hsync_o) cnt_hs++;
            if (!vsync_o) cnt_vs++;
        end
        chk("de_per_frame", 32'(cnt_de), 32'd32);
        chk("hs_low_per_frame", 32'(cnt_hs), 32'd24);
        chk("vs_low_per_frame", 32'(cnt_vs), 32'd32);

        // Five junk beats ahead of the first frame
        junk = 5;
        src_en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("junk_accepted", 32'(junk_acc), 32'd5);
        chk("tuser_held_tready", 32'(in_axis_tready), 32'd0);
        chk("armed_status", 32'(status_o), 32'd1);
        wait_at("pix_v2h3", 4, 2, 1'b1);
        chk("pixel_v2h3", pixel_o, 32'h0000_1003);
        chk("de_v2h3", 32'(de_o), 32'd1);
        repeat (3 * FR) @(posedge clk);

        // Upstream stalls at h=3, v=1
        wait_at("uf_frame", 0, 0, 1'b1);
        drop_arm = 1'b1;
        wait_at("uf_point", 4, 1, 1'b0);
        chk("uf_pixel_blank", pixel_o, 32'h0);
        chk("uf_flag", 32'(underflow_o), 32'd1);
        chk("uf_status", 32'(status_o), 32'd0);
        repeat (3 * FR) @(posedge clk);
        #1 chk("uf_sticky", 32'(underflow_o), 32'd1);

        // Early tlast on h=6 of line 0
        wait_at("tl_frame", 0, 0, 1'b1);
        lerr = 1'b1;
        wait_at("tl_point", 7, 0, 1'b0);
        chk("tl_sync_err", 32'(sync_err_o), 32'd1);
        chk("tl_pixel_shown", pixel_o, 32'h0000_0006);
        chk("tl_status", 32'(status_o), 32'd0);
        @(posedge clk); #1;
        chk("tl_next_blank", pixel_o, 32'h0);
        repeat (2 * FR) @(posedge clk);

        // Reset pulse mid-frame while running
        wait_at("rst_point", 4, 2, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_de", 32'(de_o), 32'd0);
        chk("rst_hsync", 32'(hsync_o), 32'd1);
        chk("rst_vsync", 32'(vsync_o), 32'd1);
        chk("rst_underflow", 32'(underflow_o), 32'd0);
        chk("rst_sync_err", 32'(sync_err_o), 32'd0);
        chk("rst_status", 32'(status_o), 32'd0);
        repeat (3 * FR) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
